hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed below (clock and reset first).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  instruction present in ID.
REQ-005 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-006 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 id_dst  in  5  ID destination register.
REQ-008 id_we  in  1  ID instruction writes the register file.
REQ-009 id_load  in  1  ID instruction is a load.
REQ-010 fwd_rs_sel, fwd_rt_sel  out  2 each  EX operand select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB write data, 11 never driven.
REQ-011 stall  out  1  hold PC and IF/ID this cycle; insert bubble into EX.

Function
REQ-012 The block SHALL keep shadow tag stages: EX {rs, rt, use_rs, use_rt, dst, we, load}, MEM {dst, we, load}, WB {dst, we}.
REQ-013 On each rising edge with stall=0: ID→EX (we forced 0 when id_valid=0), EX→MEM, MEM→WB.
REQ-014 On a rising edge with stall=1: EX SHALL load a bubble (we=0, load=0, use_rs=0, use_rt=0); EX→MEM and MEM→WB SHALL still advance.
REQ-015 stall SHALL be combinational: 1 iff id_valid & ex_we & ex_load & ex_dst≠0 & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst)).
REQ-016 Each EX select SHALL be combinational from registered tags; priority MEM over WB over register file.
REQ-017 fwd_x_sel=01 iff ex_use_x & mem_we & mem_dst≠0 & mem_dst==ex_x.
REQ-018 Else fwd_x_sel=10 iff ex_use_x & wb_we & wb_dst≠0 & wb_dst==ex_x.
REQ-019 Else fwd_x_sel=00.
REQ-020 Register 0 SHALL never forward or stall, whatever the we bits.
REQ-021 A load in MEM matching an EX operand SHALL be unreachable by construction (REQ-014); the select for that case SHALL still follow REQ-017.
REQ-022 Back-to-back load-use: stall SHALL last exactly one cycle per load; after the bubble the consumer SHALL get sel=10.
REQ-023 Same-cycle WB→ID read SHALL be the register file's job; this block SHALL NOT cover it.
REQ-024 Selects SHALL never be 11.

Reset
REQ-025 While reset=1 at a clock edge, all stage we, load and use bits SHALL clear and all tag fields SHALL go to 0.
REQ-026 After reset: fwd_rs_sel=fwd_rt_sel=00 and stall=0.
REQ-027 Reset SHALL win over stall in the same cycle. Any in-flight hazard SHALL be discarded.

Structure
REQ-028 A shared package SHALL define FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10, REG_ZERO=5'd0, and REG_W=5.
REQ-029 The datapath's 3-input operand muxes SHALL use the same package encoding.
REQ-030 The select compare logic SHALL be one sub-module, fwd_sel_cmp, instantiated twice (rs, rt).
REQ-031 fwd_sel_cmp inputs SHALL be: ex_reg, ex_use, mem_dst, mem_we, wb_dst, wb_we. Its output SHALL be the 2-bit select.
REQ-032 Tag stages SHALL be plain registers in the top module.

Verification
REQ-033 Test 1: add $3 then sub $4,$3,$5 on consecutive cycles -> SHALL give fwd_rs_sel=01 with sub in EX, fwd_rt_sel=00 and stall=0.
REQ-034 Test 2: add $3, then an unrelated instruction, then or $6,$3,$3 -> SHALL give fwd_rs_sel=fwd_rt_sel=10 with or in EX.
REQ-035 Test 3: lw $2 then add $7,$2,$1 -> SHALL give stall=1 for exactly one cycle; EX holds a bubble; next cycle add in EX gives fwd_rs_sel=10.
REQ-036 Test 4: writes to $0 in MEM and WB with an EX read of $0, plus lw $0 followed by a use -> SHALL give sel=00 and stall=0 throughout.
REQ-037 Test 5: add $8 in MEM and lw $8 in WB, EX reads $8 -> SHALL give sel=01 (MEM priority).
REQ-038 Test 6: reset asserted for one cycle while stall=1 -> next cycle stall=0, selects 00, and all stages SHALL be empty.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and tag-stage types for the EX operand forwarding / load-use stall logic.
// The datapath operand muxes decode fwd_*_sel with the same FWD_* constants.
package hazard_forward_unit_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned NUM_OPS = 2;   // rs, rt

  localparam logic [1:0]       FWD_RF   = 2'b00;
  localparam logic [1:0]       FWD_MEM  = 2'b01;
  localparam logic [1:0]       FWD_WB   = 2'b10;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic [REG_W-1:0] dst;
    logic             we;
    logic             load;
  } ex_tag_t;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             we;
    logic             load;
  } mem_tag_t;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic             we;
  } wb_tag_t;

  // A read of src is satisfied by a producer writing dst; $0 never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic rd,
                                   input logic [REG_W-1:0] dst, input logic we);
    return rd & we & (dst != REG_ZERO) & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_sel_cmp.sv
// Per-operand forward select: MEM result beats WB data beats the register file.
module fwd_sel_cmp
  import hazard_forward_unit_pkg::*;
(
  input  logic [REG_W-1:0] ex_reg,
  input  logic             ex_use,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_we,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_we,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(ex_reg, ex_use, mem_dst, mem_we))
      sel = FWD_MEM;
    else if (reg_hit(ex_reg, ex_use, wb_dst, wb_we))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Shadow register tags for EX/MEM/WB, EX operand forward selects and the load-use stall.
// Same-cycle WB->ID bypass is left to the register file's write-through.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_we,
  input  logic             id_load,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             stall
);

  ex_tag_t  ex_q;
  mem_tag_t mem_q;
  wb_tag_t  wb_q;

  // A load still in EX has no data yet for an ID consumer: hold ID one cycle.
  assign stall = id_valid & ex_q.load &
                 (reg_hit(id_rs, id_use_rs, ex_q.dst, ex_q.we) |
                  reg_hit(id_rt, id_use_rt, ex_q.dst, ex_q.we));

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= '{dst: ex_q.dst, we: ex_q.we, load: ex_q.load};
      wb_q  <= '{dst: mem_q.dst, we: mem_q.we};
      if (stall)
        ex_q <= '0;
      else
        ex_q <= '{rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt,
                  dst: id_dst, we: id_we & id_valid, load: id_load};
    end
  end

  // MEM load flag rides along for the datapath; nothing here consumes it.
  logic mem_load_unused;
  assign mem_load_unused = mem_q.load;

  logic [NUM_OPS-1:0][REG_W-1:0] ex_regs;
  logic [NUM_OPS-1:0]            ex_uses;
  logic [NUM_OPS-1:0][1:0]       sels;

  assign ex_regs = {ex_q.rt, ex_q.rs};
  assign ex_uses = {ex_q.use_rt, ex_q.use_rs};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_sel_cmp u_cmp (
        .ex_reg  (ex_regs[g]),
        .ex_use  (ex_uses[g]),
        .mem_dst (mem_q.dst),
        .mem_we  (mem_q.we),
        .wb_dst  (wb_q.dst),
        .wb_we   (wb_q.we),
        .sel     (sels[g])
      );
    end
  endgenerate

  assign fwd_rs_sel = sels[0];
  assign fwd_rt_sel = sels[1];

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit; expectations are hand-derived pipeline timing.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_we, id_load;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_dst     (id_dst),
    .id_we      (id_we),
    .id_load    (id_load),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] rs_e, input logic [1:0] rt_e,
                         input logic st_e);
    chk({tag, ".rs"}, fwd_rs_sel, rs_e);
    chk({tag, ".rt"}, fwd_rt_sel, rt_e);
    chk({tag, ".stall"}, {1'b0, stall}, {1'b0, st_e});
  endtask

  // Present an instruction in ID; outputs settle before the check #1 later.
  task automatic issue(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic we, input logic ld);
    id_valid = 1'b1; id_dst = dst; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_we = we; id_load = ld;
    #1;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_dst = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_we = 1'b0; id_load = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop(); tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk_all("reset", 2'b00, 2'b00, 1'b0);

    // Test 1: add $3,$1,$2 ; sub $4,$3,$5
    issue(5'd3, 5'd1, 5'd2, 1, 1, 1, 0); tick();
    issue(5'd4, 5'd3, 5'd5, 1, 1, 1, 0);
    chk_all("t1.id", 2'b00, 2'b00, 1'b0);
    tick(); nop();
    chk_all("t1.ex", 2'b01, 2'b00, 1'b0);
    flush();

    // Test 2: add $3 ; unrelated ; or $6,$3,$3
    issue(5'd3, 5'd1, 5'd2, 1, 1, 1, 0); tick();
    issue(5'd9, 5'd10, 5'd11, 1, 1, 1, 0); tick();
    issue(5'd6, 5'd3, 5'd3, 1, 1, 1, 0); tick(); nop();
    chk_all("t2.ex", 2'b10, 2'b10, 1'b0);
    flush();

    // Test 3: lw $2 ; add $7,$2,$1 -> one-cycle stall, then WB forward
    issue(5'd2, 5'd1, 5'd0, 1, 0, 1, 1); tick();
    issue(5'd7, 5'd2, 5'd1, 1, 1, 1, 0);
    chk_all("t3.stall", 2'b00, 2'b00, 1'b1);
    tick();
    chk_all("t3.bubble", 2'b00, 2'b00, 1'b0);
    tick(); nop();
    chk_all("t3.use", 2'b10, 2'b00, 1'b0);
    flush();

    // Test 4: writes to $0 never forward; lw $0 never stalls
    issue(5'd0, 5'd1, 5'd2, 1, 1, 1, 0); tick();
    issue(5'd0, 5'd1, 5'd2, 1, 1, 1, 0); tick();
    issue(5'd5, 5'd0, 5'd0, 1, 1, 1, 0); tick(); nop();
    chk_all("t4.r0fwd", 2'b00, 2'b00, 1'b0);
    flush();
    issue(5'd0, 5'd1, 5'd0, 1, 0, 1, 1); tick();
    issue(5'd5, 5'd0, 5'd0, 1, 1, 1, 0);
    chk_all("t4.r0stall", 2'b00, 2'b00, 1'b0);
    tick(); nop();
    chk_all("t4.r0use", 2'b00, 2'b00, 1'b0);
    flush();

    // Test 5: lw $8 in WB, add $8 in MEM, EX reads $8 -> MEM wins
    issue(5'd8, 5'd1, 5'd0, 1, 0, 1, 1); tick();
    issue(5'd8, 5'd1, 5'd1, 1, 1, 1, 0);
    chk_all("t5.nostall", 2'b00, 2'b00, 1'b0);
    tick();
    issue(5'd12, 5'd8, 5'd8, 1, 1, 1, 0); tick(); nop();
    chk_all("t5.prio", 2'b01, 2'b01, 1'b0);
    flush();

    // Test 5b: use bit gates the forward even when tags match
    issue(5'd8, 5'd1, 5'd1, 1, 1, 1, 0); tick();
    issue(5'd12, 5'd8, 5'd8, 0, 1, 1, 0); tick(); nop();
    chk_all("t5b.use", 2'b00, 2'b01, 1'b0);
    flush();

    // Test 6: reset during a stall discards the hazard and empties all stages
    issue(5'd2, 5'd1, 5'd0, 1, 0, 1, 1); tick();
    issue(5'd7, 5'd2, 5'd2, 1, 1, 1, 0);
    chk_all("t6.pre", 2'b00, 2'b00, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_all("t6.post", 2'b00, 2'b00, 1'b0);
    issue(5'd7, 5'd2, 5'd2, 1, 1, 1, 0); tick(); nop();
    chk_all("t6.empty", 2'b00, 2'b00, 1'b0);
    tick();
    chk_all("t6.empty2", 2'b00, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
